// File: rtl/vec_pixel_loader.sv
// Packs consecutive 8-bit pixels from the input pixel memory into LANES-wide vectors.
// Optional LOADER_PREFETCH_EN adds a second pixel buffer so fetching overlaps consumer backpressure.
module vec_pixel_loader #(
  parameter int WIDTH  = 24,
  parameter int AMOUNT = 90000,
  parameter int PIXEL  = 8,
  parameter int LANES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [WIDTH-1:0]       i_base_addr,
  input  logic [WIDTH-1:0]       i_nvec,
  output logic [WIDTH-1:0]       o_mem_addr,
  input  logic [WIDTH-1:0]       i_mem_rd,
  output logic [LANES*PIXEL-1:0] o_vec_data,
  output logic                   o_vec_valid,
  input  logic                   i_vec_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int               LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int               VW        = LANES * PIXEL;
  localparam logic [WIDTH-1:0] AMT       = WIDTH'(AMOUNT);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_vleft;
  logic [LW-1:0]    r_lane;
  logic [VW-1:0]    r_vecData;
  logic             r_vecValid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_memAddrHold;

  logic             w_oob;
  logic [PIXEL-1:0] w_pixel;
  logic             w_hs;
  logic             w_lastVec;
  logic             w_fetchEn;
  logic             w_unused;

  // Only the low PIXEL bits of the memory word carry the pixel.
  assign w_unused  = |i_mem_rd[WIDTH-1:PIXEL];

  assign w_oob     = (r_addr >= AMT);
  assign w_pixel   = w_oob ? '0 : i_mem_rd[PIXEL-1:0];
  assign w_hs      = r_vecValid && i_vec_ready;
  assign w_lastVec = (r_vleft == WIDTH'(1));

  assign o_mem_addr  = w_fetchEn ? r_addr : r_memAddrHold;
  assign o_vec_data  = r_vecData;
  assign o_vec_valid = r_vecValid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

`ifdef LOADER_PREFETCH_EN

  logic [VW-1:0]    r_fill;
  logic             r_fillFull;
  logic [WIDTH-1:0] r_fetchLeft;

  logic [VW-1:0]    w_fillNext;
  logic             w_fillDone;
  logic             w_outFree;
  logic             w_nextValid;

  // Fetch runs in FETCH and HOLD until every requested pixel is read or the spare buffer is full.
  assign w_fetchEn   = ((r_state == S_FETCH) || (r_state == S_HOLD)) &&
                       (r_fetchLeft != '0) && !r_fillFull;
  assign w_fillDone  = w_fetchEn && (r_lane == LAST_LANE);
  assign w_outFree   = !r_vecValid || w_hs;
  assign w_nextValid = (w_fillDone && w_outFree) || (r_fillFull && w_outFree) ||
                       (r_vecValid && !w_hs);

  always_comb begin
    w_fillNext = r_fill;
    w_fillNext[int'(r_lane)*PIXEL +: PIXEL] = w_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_vleft       <= '0;
      r_lane        <= '0;
      r_vecData     <= '0;
      r_vecValid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_memAddrHold <= '0;
      r_fill        <= '0;
      r_fillFull    <= 1'b0;
      r_fetchLeft   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_vleft     <= i_nvec;
            r_fetchLeft <= i_nvec;
            r_err       <= 1'b0;
            r_lane      <= '0;
            r_fillFull  <= 1'b0;
            r_busy      <= 1'b1;
            if (i_nvec == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_FETCH, S_HOLD: begin
          if (w_fetchEn) begin
            r_memAddrHold <= r_addr;
            r_fill        <= w_fillNext;
            r_addr        <= r_addr + WIDTH'(1);
            if (w_oob) r_err <= 1'b1;
            if (r_lane == LAST_LANE) begin
              r_lane      <= '0;
              r_fetchLeft <= r_fetchLeft - WIDTH'(1);
            end else begin
              r_lane <= r_lane + LW'(1);
            end
          end

          // A freshly completed vector bypasses the spare buffer when the output slot frees up.
          if (w_fillDone && w_outFree) begin
            r_vecData <= w_fillNext;
          end else if (w_fillDone) begin
            r_fillFull <= 1'b1;
          end else if (r_fillFull && w_outFree) begin
            r_vecData  <= r_fill;
            r_fillFull <= 1'b0;
          end

          if (w_hs) r_vleft <= r_vleft - WIDTH'(1);

          if (w_hs && w_lastVec) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_vecValid <= 1'b0;
          end else begin
            r_vecValid <= w_nextValid;
            r_state    <= w_nextValid ? S_HOLD : S_FETCH;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`else

  assign w_fetchEn = (r_state == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_vleft       <= '0;
      r_lane        <= '0;
      r_vecData     <= '0;
      r_vecValid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_memAddrHold <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_vleft <= i_nvec;
            r_err   <= 1'b0;
            r_lane  <= '0;
            r_busy  <= 1'b1;
            if (i_nvec == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          r_memAddrHold <= r_addr;
          r_vecData[int'(r_lane)*PIXEL +: PIXEL] <= w_pixel;
          r_addr <= r_addr + WIDTH'(1);
          if (w_oob) r_err <= 1'b1;
          if (r_lane == LAST_LANE) begin
            r_lane     <= '0;
            r_vecValid <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_lane <= r_lane + LW'(1);
          end
        end

        S_HOLD: begin
          if (w_hs) begin
            r_vecValid <= 1'b0;
            r_vleft    <= r_vleft - WIDTH'(1);
            if (w_lastVec) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_lane  <= '0;
              r_state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: doc/vec_pixel_loader.md
# vec_pixel_loader

Streams 8-bit pixels out of the input pixel memory and packs them into LANES-wide vectors for the vector datapath. It sits directly downstream of the input data memory: it drives that memory's combinational read address, captures one pixel per cycle, and hands each completed vector to the vector register write port over a valid/ready handshake. A single start command loads `nvec` consecutive vectors beginning at `base_addr`.

## Interface
- `WIDTH`, 24: address width; also the width of the memory read-data word.
- `AMOUNT`, 90000: number of pixels in the memory (300x300 image).
- `PIXEL`, 8: pixel width; only `mem_rd[PIXEL-1:0]` is used.
- `LANES`, 4: pixels per vector (≥2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command; sampled only in IDLE.
- `base_addr`  in  WIDTH  first pixel address; sampled with `start`.
- `nvec`  in  WIDTH  number of vectors to load; sampled with `start`.
- `mem_addr`  out  WIDTH  read address to the pixel memory; the memory returns data in the same cycle.
- `mem_rd`  in  WIDTH  read data from the pixel memory (zero-extended pixel).
- `vec_data`  out  LANES*PIXEL  packed vector; lane 0 (lowest address) in `[PIXEL-1:0]`.
- `vec_valid`  out  1  `vec_data` is valid.
- `vec_ready`  in  1  consumer accepts when `vec_valid && vec_ready` at a rising edge.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last vector is accepted.
- `err`  out  1  sticky; set when any fetched address is ≥ AMOUNT. Cleared by the next accepted `start`.

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE: when `start`=1, latch `base_addr` into address counter `addr`, `nvec` into `vleft`, clear `err`, and clear lane counter `lane`. Go to DONE if `nvec`=0, otherwise go to FETCH.
- FETCH: `mem_addr`=`addr`. Each cycle, write `mem_rd[PIXEL-1:0]` into lane `lane`; `addr`+=1 and `lane`+=1.
  - If `addr` ≥ AMOUNT, store 0 in the lane instead and set `err`.
  - After lane LANES-1 is written, go to HOLD.
- HOLD: `vec_valid`=1 and `vec_data` is stable. On handshake, `vleft`-=1. If `vleft` becomes 0, go to DONE; otherwise clear `lane` and go to FETCH.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE.
- `addr` is WIDTH bits and wraps modulo 2^WIDTH. Wrapped addresses ≥ AMOUNT still zero-fill and set `err`.
- `mem_addr` holds its last value outside FETCH.
- Reset (any time, including mid-load): state=IDLE and all outputs 0 (`mem_addr`, `vec_data`, `vec_valid`, `busy`, `done`, `err`). Any partial vector is discarded.

## Timing
- Latency: `start` sampled at edge E0. The first vector is valid from edge E0+LANES+1.
- Throughput without prefetch, with `vec_ready` held high: one vector per LANES+1 cycles.
- `done` asserts in the cycle after the final handshake edge.
- `busy` rises the cycle after the `start` edge and falls together with `done`.
- `vec_valid` never drops without a handshake.

## Configuration
- `LOADER_PREFETCH_EN` defined:
  - A second LANES-pixel buffer is added, and FETCH continues into it while HOLD waits for `vec_ready`.
  - On handshake, if the second buffer is full, it moves to `vec_data` and `vec_valid` stays 1.
  - With `vec_ready` held high, throughput is one vector per LANES cycles.
  - Fetching stalls when both buffers are full.
  - Total pixels fetched never exceeds `nvec`*LANES.
- `LOADER_PREFETCH_EN` undefined: single buffer, with the behaviour described above.

## Test plan
- Reset mid-FETCH: assert `rst_n`=0 during lane 2 → all outputs 0 immediately. After release, no `vec_valid` until a new `start`.
- Single vector: memory holds 0x11, 0x22, 0x33, 0x44 at 100..103; `start`, `base_addr`=100, `nvec`=1, `vec_ready`=1 → `vec_data`=0x44332211 valid at E0+5. `done` pulses at E0+6, `err`=0.
- Backpressure: `nvec`=2, `base_addr`=0; hold `vec_ready`=0 for 10 cycles → `vec_data` stays stable. After release, the second vector holds pixels 4..7 and `done` pulses once.
- Out of range: `base_addr`=89998, `nvec`=1 → lanes 0–1 hold the memory contents, lanes 2–3 are 0, and `err`=1 until the next `start`.
- Zero count and ignored start: `nvec`=0 → `done` pulses at E0+1 with no `vec_valid`. A second `start` pulsed during a 3-vector load is ignored: exactly 3 vectors are delivered and one `done` pulse occurs.
- With `LOADER_PREFETCH_EN`: `nvec`=4 and `vec_ready`=1 → handshakes arrive every 4 cycles after the first vector, and pixels 0..15 are delivered in order.
